// File: rtl/bank_pkg.sv
// Shared bank word geometry used by the write-side packer and the read-side byte selector.
package bank_pkg;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned WORD_W    = LANES * LANE_W;
  localparam int unsigned LANE_BITS = $clog2(LANES);

  typedef logic [LANE_BITS-1:0] lane_t;
  typedef logic [LANES-1:0]     be_t;
  typedef logic [LANE_W-1:0]    byte_t;
  typedef logic [WORD_W-1:0]    word_t;

  localparam byte_t PAD = 8'h00;

  // Lanes without an enable carry PAD instead of stale assembly data.
  function automatic word_t pad_word(input word_t w, input be_t be);
    pad_word = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pad_word[i*LANE_W +: LANE_W] = be[i] ? w[i*LANE_W +: LANE_W] : PAD;
    end
  endfunction
endpackage

// File: rtl/bank_byte_packer_if.sv
// Byte-stream input and bank-word output handshakes of the byte packer.
interface bank_byte_packer_if;
  import bank_pkg::*;

  byte_t byte_in;
  logic  byte_valid;
  logic  byte_ready;
  logic  flush;
  word_t word_out;
  be_t   word_be;
  logic  word_valid;
  logic  word_ready;
  logic  busy;

  modport master (
    output byte_in, byte_valid, flush, word_ready,
    input  byte_ready, word_out, word_be, word_valid, busy
  );

  modport slave (
    input  byte_in, byte_valid, flush, word_ready,
    output byte_ready, word_out, word_be, word_valid, busy
  );
endinterface

// File: rtl/bank_word_slot.sv
// One-entry valid/ready output register holding a closed bank word until the sink takes it.
module bank_word_slot
  import bank_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  word_t load_word,
  input  be_t   load_be,
  input  logic  out_ready,
  output word_t out_word,
  output be_t   out_be,
  output logic  out_valid,
  output logic  can_load
);
  assign can_load = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word  <= '0;
      out_be    <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_word  <= load_word;
      out_be    <= load_be;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/bank_byte_packer.sv
// Packs a byte stream little-endian into bank words with per-lane byte enables; flush closes partials.
module bank_byte_packer
  import bank_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  bank_byte_packer_if.slave bus
);
  word_t asm_word, nxt_word, slot_word;
  be_t   asm_be, nxt_be, slot_be;
  lane_t lane;
  logic  asm_full, accept, close, load, slot_can_load, slot_valid;

  // While asm_full no byte is accepted, so nxt_* equals the held word and serves both load paths.
  always_comb begin
    accept   = bus.byte_valid & ~asm_full;
    nxt_word = asm_word;
    nxt_be   = asm_be;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (accept && lane == lane_t'(i)) begin
        nxt_word[i*LANE_W +: LANE_W] = bus.byte_in;
        nxt_be[i]                    = 1'b1;
      end
    end
    close = ~asm_full & ((accept & (lane == lane_t'(LANES-1))) |
                         (bus.flush & (nxt_be != '0)));
    load  = slot_can_load & (asm_full | close);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_word <= '0;
      asm_be   <= '0;
      lane     <= '0;
      asm_full <= 1'b0;
    end else if (asm_full) begin
      if (slot_can_load) begin
        asm_full <= 1'b0;
        asm_be   <= '0;
      end
    end else if (close) begin
      lane     <= '0;
      asm_word <= nxt_word;
      if (slot_can_load) begin
        asm_be <= '0;
      end else begin
        asm_be   <= nxt_be;
        asm_full <= 1'b1;
      end
    end else if (accept) begin
      asm_word <= nxt_word;
      asm_be   <= nxt_be;
      lane     <= lane + lane_t'(1);
    end
  end

  bank_word_slot u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_word (pad_word(nxt_word, nxt_be)),
    .load_be   (nxt_be),
    .out_ready (bus.word_ready),
    .out_word  (slot_word),
    .out_be    (slot_be),
    .out_valid (slot_valid),
    .can_load  (slot_can_load)
  );

  assign bus.word_out   = slot_word;
  assign bus.word_be    = slot_be;
  assign bus.word_valid = slot_valid;
  assign bus.byte_ready = ~asm_full;
  assign bus.busy       = (asm_be != '0) | asm_full | slot_valid;
endmodule

// File: tb/tb_bank_byte_packer.sv
// Directed and randomized-stall checks of bank_byte_packer against hand-computed words and a stream model.
module tb_bank_byte_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  bank_byte_packer_if bus ();

  bank_byte_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input logic fl);
    @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    bus.flush      = fl;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Stream-level reference: bytes fill lanes in order, flush closes a non-empty word.
  bit            sb_on = 1'b0;
  logic [35:0]   exp_q[$];
  logic [31:0]   m_word = '0;
  int            m_n = 0;

  always @(posedge clk) begin
    if (sb_on && rst_n) begin
      if (bus.word_valid && bus.word_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", bus.word_out, 32'hxxxxxxxx);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          chk("sb_word", bus.word_out, e[31:0]);
          chk("sb_be", {28'd0, bus.word_be}, {28'd0, e[35:32]});
        end
      end
      if (bus.byte_valid && bus.byte_ready) begin
        m_word[m_n*8 +: 8] = bus.byte_in;
        m_n++;
        if (m_n == 4) begin
          exp_q.push_back({4'hF, m_word});
          m_n    = 0;
          m_word = '0;
        end
      end
      if (bus.flush && bus.byte_ready && m_n > 0) begin
        exp_q.push_back({4'((1 << m_n) - 1), m_word});
        m_n    = 0;
        m_word = '0;
      end
    end
  end

  initial begin
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst_word", bus.word_out, 32'd0);
    chk("rst_be", {28'd0, bus.word_be}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.byte_ready}, 32'd1);

    // 1: full word, latency one cycle after the fourth byte
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0);
    chk("t1_no_early", {31'd0, bus.word_valid}, 32'd0);
    put(8'h44, 0);
    chk("t1_valid", {31'd0, bus.word_valid}, 32'd1);
    chk("t1_word", bus.word_out, 32'h44332211);
    chk("t1_be", {28'd0, bus.word_be}, 32'hF);
    idle(1);
    chk("t1_drained", {31'd0, bus.word_valid}, 32'd0);

    // 2: partial word on flush, second flush is a no-op
    put(8'hAA, 0); put(8'hBB, 0);
    chk("t2_busy", {31'd0, bus.busy}, 32'd1);
    pulse_flush();
    chk("t2_valid", {31'd0, bus.word_valid}, 32'd1);
    chk("t2_word", bus.word_out, 32'h0000BBAA);
    chk("t2_be", {28'd0, bus.word_be}, 32'h3);
    idle(1);
    pulse_flush();
    chk("t2_noword", {31'd0, bus.word_valid}, 32'd0);
    chk("t2_idle", {31'd0, bus.busy}, 32'd0);

    // 3: back-pressure, second word parks in assembly
    bus.word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) put(8'(i), 0);
    chk("t3_held", bus.word_out, 32'h04030201);
    chk("t3_full_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("t3_busy", {31'd0, bus.busy}, 32'd1);
    pulse_flush();
    chk("t3_flush_ign", bus.word_out, 32'h04030201);
    chk("t3_still_full", {31'd0, bus.byte_ready}, 32'd0);
    @(negedge clk);
    bus.word_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_second", bus.word_out, 32'h08070605);
    chk("t3_second_be", {28'd0, bus.word_be}, 32'hF);
    chk("t3_ready_back", {31'd0, bus.byte_ready}, 32'd1);
    idle(1);
    chk("t3_drained", {31'd0, bus.word_valid}, 32'd0);

    // 4: flush together with an accept
    put(8'h0A, 0); put(8'h0B, 0); put(8'hCC, 1);
    chk("t4_word3", bus.word_out, 32'h00CC0B0A);
    chk("t4_be3", {28'd0, bus.word_be}, 32'h7);
    put(8'h01, 0);
    chk("t4_gap", {31'd0, bus.word_valid}, 32'd0);
    put(8'h02, 0); put(8'h03, 0); put(8'h04, 1);
    chk("t4_word4", bus.word_out, 32'h04030201);
    chk("t4_be4", {28'd0, bus.word_be}, 32'hF);
    idle(1);
    chk("t4_single", {31'd0, bus.word_valid}, 32'd0);

    // 5: asynchronous reset discards pending words
    bus.word_ready = 1'b0;
    put(8'h11, 0); put(8'h12, 0); put(8'h13, 0); put(8'h14, 0);
    put(8'h21, 0); put(8'h22, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("t5_word", bus.word_out, 32'd0);
    chk("t5_be", {28'd0, bus.word_be}, 32'd0);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_ready", {31'd0, bus.byte_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.word_ready = 1'b1;
    put(8'h31, 0); put(8'h32, 0); put(8'h33, 0); put(8'h34, 0);
    chk("t5_word_after", bus.word_out, 32'h34333231);
    chk("t5_be_after", {28'd0, bus.word_be}, 32'hF);
    idle(2);

    // 6: random valid/ready stalls and flushes against the stream model
    begin
      int  sent = 0;
      int  cyc  = 0;
      bit  hs   = 1'b0;
      logic r0;
      @(negedge clk);
      sb_on = 1'b1;
      while (sent < 1000 && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (hs) bus.byte_valid = 1'b0;
        if (!bus.byte_valid && $urandom_range(0, 3) != 0) begin
          bus.byte_valid = 1'b1;
          bus.byte_in    = 8'($urandom);
        end
        bus.word_ready = ($urandom_range(0, 3) != 0);
        bus.flush      = ($urandom_range(0, 15) == 0);
        if (cyc % 37 == 0) begin
          r0 = bus.byte_ready;
          bus.byte_valid = ~bus.byte_valid;
          #1;
          chk("t6_ready_indep", {31'd0, bus.byte_ready}, {31'd0, r0});
          bus.byte_valid = ~bus.byte_valid;
        end
        hs = bus.byte_valid && bus.byte_ready;
        if (hs) sent++;
      end
      chk("t6_bytes_sent", sent, 1000);
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.flush      = 1'b0;
      bus.word_ready = 1'b1;
      repeat (4) @(negedge clk);
      pulse_flush();
      idle(4);
      sb_on = 1'b0;
      chk("t6_sb_left", exp_q.size(), 0);
      chk("t6_idle", {31'd0, bus.busy}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
